// File: rtl/ppg_sched_pkg.sv
// Shared definitions for the PPG phase scheduler: interface widths, FSM state
// encoding and the phase identifiers used when entering a *_SET state.
package ppg_sched_pkg;

   localparam int DC_W  = 7;
   localparam int PGA_W = 4;
   localparam int ADC_W = 8;
   localparam int DRV_W = 4;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RED_SET = 3'd1;
   localparam logic [2:0] ST_RED_ACQ = 3'd2;
   localparam logic [2:0] ST_IR_SET  = 3'd3;
   localparam logic [2:0] ST_IR_ACQ  = 3'd4;
   localparam logic [2:0] ST_AMB_SET = 3'd5;
   localparam logic [2:0] ST_AMB_ACQ = 3'd6;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      RED_SET = ST_RED_SET,
      RED_ACQ = ST_RED_ACQ,
      IR_SET  = ST_IR_SET,
      IR_ACQ  = ST_IR_ACQ,
      AMB_SET = ST_AMB_SET,
      AMB_ACQ = ST_AMB_ACQ
   } state_e;

   typedef enum logic [1:0] {
      PH_RED = 2'd0,
      PH_IR  = 2'd1,
      PH_AMB = 2'd2
   } phase_e;

endpackage

// File: rtl/ppg_phase_avg.sv
// Sample accumulator shared by all three phases.
// Ports:
//   CLK, rst_n  clock, asynchronous active-low reset
//   clr         hold accumulator and sample counter at zero
//   en          add ADC this cycle (phase acquisition active)
//   ADC         front-end sample
//   done        high in the last of the 2^AVG_LOG2 acquisition cycles
//   avg         (accumulated total including this cycle's ADC) >> AVG_LOG2
module ppg_phase_avg
   import ppg_sched_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [ADC_W-1:0] ADC,
   output logic             done,
   output logic [ADC_W-1:0] avg
);

   localparam int N     = 1 << AVG_LOG2;
   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // The final sample is folded in combinationally so the average is
      // available at the same edge that ends the acquisition.
      sum  = acc_q + ACC_W'(ADC);
      done = en && !clr && (cnt_q == CNT_W'(N - 1));
      avg  = ADC_W'(sum >> AVG_LOG2);
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr || done) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (en) begin
         acc_d = sum;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ppg_phase_scheduler.sv
// Time-multiplexes the analog front end across RED, IR and AMBIENT phases.
// Each phase applies its LED/DC-comp/PGA settings, settles for SETTLE_CYC
// cycles, then averages 2^AVG_LOG2 ADC samples and strobes the result.
// Ports:
//   CLK, rst_n                      clock, asynchronous active-low reset
//   enable, cal_done                frames run only while both are high
//   red_dc/red_pga/ir_dc/ir_pga     per-channel calibration settings
//   led_drive_cfg                   LED current for RED/IR phases
//   ADC                             front-end sample
//   LED_RED/LED_IR/LED_DRIVE        LED driver controls
//   DC_Comp/PGA_Gain                front-end DAC and gain codes
//   red/ir/amb_sample + _valid      averaged samples with 1-cycle strobes
//   frame_start                     1-cycle strobe on entry to RED_SET
module ppg_phase_scheduler
   import ppg_sched_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int AVG_LOG2   = 2
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cal_done,
   input  logic [DC_W-1:0]  red_dc,
   input  logic [PGA_W-1:0] red_pga,
   input  logic [DC_W-1:0]  ir_dc,
   input  logic [PGA_W-1:0] ir_pga,
   input  logic [DRV_W-1:0] led_drive_cfg,
   input  logic [ADC_W-1:0] ADC,
   output logic             LED_RED,
   output logic             LED_IR,
   output logic [DRV_W-1:0] LED_DRIVE,
   output logic [DC_W-1:0]  DC_Comp,
   output logic [PGA_W-1:0] PGA_Gain,
   output logic [ADC_W-1:0] red_sample,
   output logic [ADC_W-1:0] ir_sample,
   output logic [ADC_W-1:0] amb_sample,
   output logic             red_valid,
   output logic             ir_valid,
   output logic             amb_valid,
   output logic             frame_start
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   state_e           state_q, state_d;
   logic [SET_W-1:0] set_cnt_q, set_cnt_d;
   logic [DC_W-1:0]  sh_red_dc_q, sh_red_dc_d, sh_ir_dc_q, sh_ir_dc_d;
   logic [PGA_W-1:0] sh_red_pga_q, sh_red_pga_d, sh_ir_pga_q, sh_ir_pga_d;
   logic [DRV_W-1:0] sh_drv_q, sh_drv_d;
   logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
   logic [DRV_W-1:0] led_drive_q, led_drive_d;
   logic [DC_W-1:0]  dc_comp_q, dc_comp_d;
   logic [PGA_W-1:0] pga_q, pga_d;
   logic [ADC_W-1:0] red_sample_q, red_sample_d, ir_sample_q, ir_sample_d;
   logic [ADC_W-1:0] amb_sample_q, amb_sample_d;
   logic             red_valid_q, red_valid_d, ir_valid_q, ir_valid_d;
   logic             amb_valid_q, amb_valid_d, frame_start_q, frame_start_d;

   logic             run, acq, in_set, settle_done, enter_set, avg_done;
   logic [ADC_W-1:0] avg;
   phase_e           enter_ph;

   assign run         = enable && cal_done;
   assign acq         = (state_q == RED_ACQ) || (state_q == IR_ACQ) || (state_q == AMB_ACQ);
   assign in_set      = (state_q == RED_SET) || (state_q == IR_SET) || (state_q == AMB_SET);
   assign settle_done = (set_cnt_q == SET_W'(SETTLE_CYC - 1));

   ppg_phase_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
      .CLK   (CLK),
      .rst_n (rst_n),
      .clr   (!acq),
      .en    (acq && run),
      .ADC   (ADC),
      .done  (avg_done),
      .avg   (avg)
   );

   always_comb begin
      state_d       = state_q;
      set_cnt_d     = set_cnt_q;
      sh_red_dc_d   = sh_red_dc_q;
      sh_red_pga_d  = sh_red_pga_q;
      sh_ir_dc_d    = sh_ir_dc_q;
      sh_ir_pga_d   = sh_ir_pga_q;
      sh_drv_d      = sh_drv_q;
      led_red_d     = led_red_q;
      led_ir_d      = led_ir_q;
      led_drive_d   = led_drive_q;
      dc_comp_d     = dc_comp_q;
      pga_d         = pga_q;
      red_sample_d  = red_sample_q;
      ir_sample_d   = ir_sample_q;
      amb_sample_d  = amb_sample_q;
      red_valid_d   = 1'b0;
      ir_valid_d    = 1'b0;
      amb_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      enter_set     = 1'b0;
      enter_ph      = PH_RED;

      if (in_set)
         set_cnt_d = settle_done ? '0 : set_cnt_q + SET_W'(1);

      case (state_q)
         IDLE:    if (run) enter_set = 1'b1;
         RED_SET: if (settle_done) state_d = RED_ACQ;
         IR_SET:  if (settle_done) state_d = IR_ACQ;
         AMB_SET: if (settle_done) state_d = AMB_ACQ;
         RED_ACQ: if (run && avg_done) begin
            red_sample_d = avg;
            red_valid_d  = 1'b1;
            enter_set    = 1'b1;
            enter_ph     = PH_IR;
         end
         IR_ACQ: if (run && avg_done) begin
            ir_sample_d = avg;
            ir_valid_d  = 1'b1;
            enter_set   = 1'b1;
            enter_ph    = PH_AMB;
         end
         AMB_ACQ: if (run && avg_done) begin
            amb_sample_d = avg;
            amb_valid_d  = 1'b1;
            enter_set    = 1'b1;
            enter_ph     = PH_RED;
         end
         default: state_d = IDLE;
      endcase

      // Losing enable/cal_done overrides everything: the partial phase is
      // discarded and the front end is parked.
      if (!run) begin
         state_d     = IDLE;
         set_cnt_d   = '0;
         led_red_d   = 1'b0;
         led_ir_d    = 1'b0;
         led_drive_d = '0;
         dc_comp_d   = '0;
         pga_d       = '0;
      end else if (enter_set) begin
         set_cnt_d = '0;
         case (enter_ph)
            PH_RED: begin
               // Shadows load on this same edge, so the RED settings come
               // straight from the inputs.
               state_d       = RED_SET;
               frame_start_d = 1'b1;
               sh_red_dc_d   = red_dc;
               sh_red_pga_d  = red_pga;
               sh_ir_dc_d    = ir_dc;
               sh_ir_pga_d   = ir_pga;
               sh_drv_d      = led_drive_cfg;
               led_red_d     = 1'b1;
               led_ir_d      = 1'b0;
               led_drive_d   = led_drive_cfg;
               dc_comp_d     = red_dc;
               pga_d         = red_pga;
            end
            PH_IR: begin
               state_d     = IR_SET;
               led_red_d   = 1'b0;
               led_ir_d    = 1'b1;
               led_drive_d = sh_drv_q;
               dc_comp_d   = sh_ir_dc_q;
               pga_d       = sh_ir_pga_q;
            end
            default: begin
               // Ambient reuses the RED front-end settings with LEDs dark.
               state_d     = AMB_SET;
               led_red_d   = 1'b0;
               led_ir_d    = 1'b0;
               led_drive_d = '0;
               dc_comp_d   = sh_red_dc_q;
               pga_d       = sh_red_pga_q;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         set_cnt_q     <= '0;
         sh_red_dc_q   <= '0;
         sh_red_pga_q  <= '0;
         sh_ir_dc_q    <= '0;
         sh_ir_pga_q   <= '0;
         sh_drv_q      <= '0;
         led_red_q     <= 1'b0;
         led_ir_q      <= 1'b0;
         led_drive_q   <= '0;
         dc_comp_q     <= '0;
         pga_q         <= '0;
         red_sample_q  <= '0;
         ir_sample_q   <= '0;
         amb_sample_q  <= '0;
         red_valid_q   <= 1'b0;
         ir_valid_q    <= 1'b0;
         amb_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         set_cnt_q     <= set_cnt_d;
         sh_red_dc_q   <= sh_red_dc_d;
         sh_red_pga_q  <= sh_red_pga_d;
         sh_ir_dc_q    <= sh_ir_dc_d;
         sh_ir_pga_q   <= sh_ir_pga_d;
         sh_drv_q      <= sh_drv_d;
         led_red_q     <= led_red_d;
         led_ir_q      <= led_ir_d;
         led_drive_q   <= led_drive_d;
         dc_comp_q     <= dc_comp_d;
         pga_q         <= pga_d;
         red_sample_q  <= red_sample_d;
         ir_sample_q   <= ir_sample_d;
         amb_sample_q  <= amb_sample_d;
         red_valid_q   <= red_valid_d;
         ir_valid_q    <= ir_valid_d;
         amb_valid_q   <= amb_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign LED_RED     = led_red_q;
   assign LED_IR      = led_ir_q;
   assign LED_DRIVE   = led_drive_q;
   assign DC_Comp     = dc_comp_q;
   assign PGA_Gain    = pga_q;
   assign red_sample  = red_sample_q;
   assign ir_sample   = ir_sample_q;
   assign amb_sample  = amb_sample_q;
   assign red_valid   = red_valid_q;
   assign ir_valid    = ir_valid_q;
   assign amb_valid   = amb_valid_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ppg_phase_scheduler.sv
// Directed bench for ppg_phase_scheduler. dut1 uses default timing
// (24-cycle frame), dut2 uses SETTLE_CYC=1/AVG_LOG2=0 (6-cycle frame).
module tb_ppg_phase_scheduler;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst_n = 1'b1;
   logic       enable = 1'b0, en2 = 1'b0, cal_done = 1'b0;
   logic [6:0] red_dc = '0, ir_dc = '0;
   logic [3:0] red_pga = '0, ir_pga = '0, led_drive_cfg = '0;
   logic [7:0] ADC = '0;

   logic       LED_RED, LED_IR, red_valid, ir_valid, amb_valid, frame_start;
   logic [3:0] LED_DRIVE, PGA_Gain;
   logic [6:0] DC_Comp;
   logic [7:0] red_sample, ir_sample, amb_sample;

   logic       LED_RED2, LED_IR2, red_valid2, ir_valid2, amb_valid2, frame_start2;
   logic [3:0] LED_DRIVE2, PGA_Gain2;
   logic [6:0] DC_Comp2;
   logic [7:0] red_sample2, ir_sample2, amb_sample2;

   ppg_phase_scheduler dut1 (
      .CLK(CLK), .rst_n(rst_n), .enable(enable), .cal_done(cal_done),
      .red_dc(red_dc), .red_pga(red_pga), .ir_dc(ir_dc), .ir_pga(ir_pga),
      .led_drive_cfg(led_drive_cfg), .ADC(ADC),
      .LED_RED(LED_RED), .LED_IR(LED_IR), .LED_DRIVE(LED_DRIVE),
      .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
      .red_sample(red_sample), .ir_sample(ir_sample), .amb_sample(amb_sample),
      .red_valid(red_valid), .ir_valid(ir_valid), .amb_valid(amb_valid),
      .frame_start(frame_start)
   );

   ppg_phase_scheduler #(.SETTLE_CYC(1), .AVG_LOG2(0)) dut2 (
      .CLK(CLK), .rst_n(rst_n), .enable(en2), .cal_done(cal_done),
      .red_dc(red_dc), .red_pga(red_pga), .ir_dc(ir_dc), .ir_pga(ir_pga),
      .led_drive_cfg(led_drive_cfg), .ADC(ADC),
      .LED_RED(LED_RED2), .LED_IR(LED_IR2), .LED_DRIVE(LED_DRIVE2),
      .DC_Comp(DC_Comp2), .PGA_Gain(PGA_Gain2),
      .red_sample(red_sample2), .ir_sample(ir_sample2), .amb_sample(amb_sample2),
      .red_valid(red_valid2), .ir_valid(ir_valid2), .amb_valid(amb_valid2),
      .frame_start(frame_start2)
   );

   logic [21:0] fe1, fe2;
   logic [45:0] all1, all2;
   assign fe1  = {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain,
                  red_valid, ir_valid, amb_valid, frame_start};
   assign fe2  = {LED_RED2, LED_IR2, LED_DRIVE2, DC_Comp2, PGA_Gain2,
                  red_valid2, ir_valid2, amb_valid2, frame_start2};
   assign all1 = {fe1, red_sample, ir_sample, amb_sample};
   assign all2 = {fe2, red_sample2, ir_sample2, amb_sample2};

   int vectors = 0;
   int fails   = 0;
   bit both_on = 1'b0;

   always @(negedge CLK)
      if ((LED_RED && LED_IR) || (LED_RED2 && LED_IR2)) both_on = 1'b1;

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Advances at least one cycle; ok=1 at the negedge where frame_start is seen.
   task automatic wait_fs(input int which, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLK);
         ok = (which == 1) ? frame_start : frame_start2;
      end
   endtask

   task automatic test_reset();
      int bad;
      enable = 1'b1; en2 = 1'b1; cal_done = 1'b0;
      red_dc = 7'd5; red_pga = 4'd3; ir_dc = 7'd9; ir_pga = 4'd7; led_drive_cfg = 4'd10;
      ADC = 8'h80;
      #2 rst_n = 1'b0;
      #10;
      vectors++;
      if (all1 !== '0) begin
         fails++; $display("FAIL reset_dut1: got %h expected 0", all1);
      end
      vectors++;
      if (all2 !== '0) begin
         fails++; $display("FAIL reset_dut2: got %h expected 0", all2);
      end
      @(negedge CLK);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (all1 !== '0 || all2 !== '0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         fails++; $display("FAIL idle_without_cal: %0d active cycles, expected 0", bad);
      end
      en2 = 1'b0;
   endtask

   task automatic test_const_frames();
      bit ok;
      int c;
      logic [21:0] exp;
      logic mid;
      cal_done = 1'b1;
      wait_fs(1, 30, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL first_frame_start: got 0 expected 1");
      end
      for (int k = 0; k <= 48; k++) begin
         c   = k % 24;
         mid = (c >= 8 && c < 16);
         exp = {c < 8, mid, (c < 16) ? 4'd10 : 4'd0, mid ? 7'd9 : 7'd5,
                mid ? 4'd7 : 4'd3, c == 8, c == 16, (c == 0 && k > 0), c == 0};
         vectors++;
         if (fe1 !== exp) begin
            fails++; $display("FAIL frame_cycle_%0d: got %h expected %h", k, fe1, exp);
         end
         if (k < 48) @(negedge CLK);
      end
      vectors++;
      if ({red_sample, ir_sample, amb_sample} !== {8'h80, 8'h80, 8'h80}) begin
         fails++;
         $display("FAIL const_samples: got %h %h %h expected 80 80 80",
                  red_sample, ir_sample, amb_sample);
      end
   endtask

   task automatic test_average();
      bit ok;
      wait_fs(1, 30, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL avg_frame_start: got 0 expected 1");
      end
      for (int k = 0; k <= 8; k++) begin
         if (k == 8) begin
            vectors++;
            if ({red_valid, red_sample} !== {1'b1, 8'd25}) begin
               fails++;
               $display("FAIL red_avg_truncate: got v=%b s=%0d expected v=1 s=25",
                        red_valid, red_sample);
            end
         end else begin
            case (k)
               4: ADC = 8'd10;
               5: ADC = 8'd20;
               6: ADC = 8'd30;
               7: ADC = 8'd41;
               default: ADC = 8'd200;
            endcase
            @(negedge CLK);
         end
      end
      ADC = 8'd255;
      wait_fs(1, 30, ok);
      wait_fs(1, 30, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL full_scale_frame_start: got 0 expected 1");
      end
      vectors++;
      if ({red_sample, ir_sample, amb_sample} !== {8'd255, 8'd255, 8'd255}) begin
         fails++;
         $display("FAIL full_scale_samples: got %0d %0d %0d expected 255 255 255",
                  red_sample, ir_sample, amb_sample);
      end
   endtask

   task automatic test_shadow();
      bit ok;
      wait_fs(1, 30, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL shadow_frame_start: got 0 expected 1");
      end
      step(12);
      red_dc = 7'd40;
      step(4);
      vectors++;
      if ({LED_DRIVE, DC_Comp} !== {4'd0, 7'd5}) begin
         fails++;
         $display("FAIL shadow_amb_dc: got drv=%0d dc=%0d expected drv=0 dc=5",
                  LED_DRIVE, DC_Comp);
      end
      step(8);
      vectors++;
      if ({frame_start, LED_RED, DC_Comp} !== {1'b1, 1'b1, 7'd40}) begin
         fails++;
         $display("FAIL shadow_next_frame: got fs=%b led=%b dc=%0d expected fs=1 led=1 dc=40",
                  frame_start, LED_RED, DC_Comp);
      end
      red_dc = 7'd5;
   endtask

   task automatic test_abort();
      bit ok;
      int bad;
      wait_fs(1, 30, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL abort_frame_start: got 0 expected 1");
      end
      step(9);
      ADC = 8'd0;
      step(5);
      enable = 1'b0;
      step(1);
      vectors++;
      if (fe1 !== '0) begin
         fails++; $display("FAIL abort_outputs_idle: got %h expected 0", fe1);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (fe1 !== '0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         fails++; $display("FAIL abort_stays_idle: %0d active cycles, expected 0", bad);
      end
      vectors++;
      if ({red_sample, ir_sample} !== {8'd255, 8'd255}) begin
         fails++;
         $display("FAIL abort_keeps_samples: got red=%0d ir=%0d expected 255 255",
                  red_sample, ir_sample);
      end
      enable = 1'b1;
      wait_fs(1, 3, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL restart_after_abort: got 0 expected 1");
      end
      enable = 1'b0;
   endtask

   task automatic test_short_frame();
      bit ok;
      logic [3:0] exp;
      en2 = 1'b1;
      wait_fs(2, 10, ok);
      vectors++;
      if (!ok) begin
         fails++; $display("FAIL short_frame_start: got 0 expected 1");
      end
      for (int k = 0; k <= 6; k++) begin
         case (k)
            0: exp = 4'b1000;
            2: exp = 4'b0100;
            4: exp = 4'b0010;
            6: exp = 4'b1001;
            default: exp = 4'b0000;
         endcase
         vectors++;
         if ({frame_start2, red_valid2, ir_valid2, amb_valid2} !== exp) begin
            fails++;
            $display("FAIL short_strobes_%0d: got %b expected %b", k,
                     {frame_start2, red_valid2, ir_valid2, amb_valid2}, exp);
         end
         if (k == 2) begin
            vectors++;
            if (red_sample2 !== 8'h11) begin
               fails++; $display("FAIL short_red: got %h expected 11", red_sample2);
            end
         end
         if (k == 4) begin
            vectors++;
            if (ir_sample2 !== 8'h22) begin
               fails++; $display("FAIL short_ir: got %h expected 22", ir_sample2);
            end
         end
         if (k == 6) begin
            vectors++;
            if (amb_sample2 !== 8'h33) begin
               fails++; $display("FAIL short_amb: got %h expected 33", amb_sample2);
            end
         end
         case (k)
            1: ADC = 8'h11;
            3: ADC = 8'h22;
            5: ADC = 8'h33;
            default: ADC = 8'hEE;
         endcase
         if (k < 6) @(negedge CLK);
      end
      en2 = 1'b0;
   endtask

   task automatic test_led_exclusive();
      vectors++;
      if (both_on !== 1'b0) begin
         fails++; $display("FAIL led_exclusive: got both-on=1 expected 0");
      end
   endtask

   initial begin
      test_reset();
      test_const_frames();
      test_average();
      test_shadow();
      test_abort();
      test_short_frame();
      test_led_exclusive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
